cacheline_adaptor: RTL and testbench

Responder for the cache's physical-memory port: accepts one 256-bit line read or write request from the cache datapath/control and carries it out as a 4-beat, 64-bit burst transaction on the external memory bus. Sits between the cache's pmem_* signals and main memory. Signals completion back to the cache with a one-cycle pmem_resp. No buffering beyond one line; one transaction in flight.

---
 rtl/rv32i_types.sv | 22 ++
 rtl/cacheline_adaptor.sv | 99 +++++++++
 tb/tb_cacheline_adaptor.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared rv32i type package: cacheline_adaptor line geometry, beat indexing
// and FSM state encoding.
package rv32i_types;

  localparam int unsigned LINE_W = 256;
  localparam int unsigned BEAT_W = 64;
  localparam int unsigned BEATS  = LINE_W / BEAT_W;

  typedef logic [$clog2(BEATS)-1:0] beat_idx_t;
  localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS - 1);

  // A cache line viewed as BEATS packed beats, beat 0 in the low bits.
  typedef logic [BEATS-1:0][BEAT_W-1:0] line_t;

  typedef enum logic [1:0] {
    CA_IDLE,
    CA_READ,
    CA_WRITE,
    CA_DONE
  } ca_state_e;

endpackage

// File: rtl/cacheline_adaptor.sv
// Bridges the cache's single-line pmem_* port to a 4-beat, 64-bit burst bus;
// one line transaction in flight, completion signalled by a one-cycle pmem_resp.
module cacheline_adaptor
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              rst_n,

  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [31:0]       pmem_address,
  input  logic [LINE_W-1:0] pmem_wdata,
  output logic [LINE_W-1:0] pmem_rdata,
  output logic              pmem_resp,

  output logic [31:0]       address_o,
  output logic              read_o,
  output logic              write_o,
  output logic [BEAT_W-1:0] burst_o,
  input  logic [BEAT_W-1:0] burst_i,
  input  logic              resp_i
);

  ca_state_e state;
  beat_idx_t cnt;
  line_t     rbuf;
  line_t     wbuf;

  assign pmem_rdata = rbuf;
  assign burst_o    = wbuf[cnt];

  // Bus-side strobes and pmem_resp are loaded together with the next state so
  // they are plain flops with no path from pmem_* or resp_i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CA_IDLE;
      cnt       <= '0;
      rbuf      <= '0;
      wbuf      <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      pmem_resp <= 1'b0;
    end else begin
      unique case (state)
        CA_IDLE: begin
          if (pmem_write) begin
            address_o <= pmem_address & ~32'h1F;
            wbuf      <= pmem_wdata;
            cnt       <= '0;
            write_o   <= 1'b1;
            state     <= CA_WRITE;
          end else if (pmem_read) begin
            address_o <= pmem_address & ~32'h1F;
            cnt       <= '0;
            read_o    <= 1'b1;
            state     <= CA_READ;
          end
        end

        CA_READ: begin
          if (resp_i) begin
            rbuf[cnt] <= burst_i;
            cnt       <= cnt + 1'b1;
            if (cnt == LAST_BEAT) begin
              read_o    <= 1'b0;
              pmem_resp <= 1'b1;
              state     <= CA_DONE;
            end
          end
        end

        CA_WRITE: begin
          if (resp_i) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_BEAT) begin
              write_o   <= 1'b0;
              pmem_resp <= 1'b1;
              state     <= CA_DONE;
            end
          end
        end

        CA_DONE: begin
          pmem_resp <= 1'b0;
          state     <= CA_IDLE;
        end

        default: begin
          read_o    <= 1'b0;
          write_o   <= 1'b0;
          pmem_resp <= 1'b0;
          state     <= CA_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: directed line transactions push
// expected responses/beats; a negedge monitor pops and compares.
module tb_cacheline_adaptor;

  logic         clk;
  logic         rst_n;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i;
  logic         resp_i;

  cacheline_adaptor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .address_o    (address_o),
    .read_o       (read_o),
    .write_o      (write_o),
    .burst_o      (burst_o),
    .burst_i      (burst_i),
    .resp_i       (resp_i)
  );

  int errors = 0;
  int checks = 0;

  logic [255:0] exp_resp[$];
  logic [63:0]  exp_wbeat[$];
  logic [31:0]  exp_addr  = '0;
  int           exp_kind  = 0;
  logic [255:0] model_rbuf = '0;

  localparam logic [255:0] R1 = {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
                                 64'h1111_1111_1111_1111, 64'h0000_0000_0000_0000};
  localparam logic [255:0] W1 = {64'h5555_AAAA_0F0F_F0F0, 64'hDEAD_BEEF_CAFE_F00D,
                                 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
  localparam logic [255:0] W2 = {64'h4444_4444_4444_4444, 64'h8888_8888_8888_8888,
                                 64'hCCCC_CCCC_CCCC_CCCC, 64'h7777_7777_7777_7777};
  localparam logic [255:0] R2 = {64'h0F1E_2D3C_4B5A_6978, 64'h8796_A5B4_C3D2_E1F0,
                                 64'h1357_9BDF_0246_8ACE, 64'hFACE_B00C_1234_5678};
  localparam logic [255:0] R3 = {64'hAAAA_0000_BBBB_1111, 64'hCCCC_2222_DDDD_3333,
                                 64'hEEEE_4444_FFFF_5555, 64'h9999_6666_8888_7777};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (read_o || write_o) begin
        check("bus_kind", {254'd0, read_o, write_o}, (exp_kind == 1) ? 256'd2 : 256'd1);
        check("address_o", {224'd0, address_o}, {224'd0, exp_addr});
      end
      if (write_o) begin
        if (exp_wbeat.size() == 0) begin
          check("wbeat_expected", 256'd0, 256'd1);
        end else begin
          check("burst_o", {192'd0, burst_o}, {192'd0, exp_wbeat[0]});
          if (resp_i) void'(exp_wbeat.pop_front());
        end
      end
      if (pmem_resp) begin
        if (exp_resp.size() == 0) begin
          check("resp_expected", 256'd0, 256'd1);
        end else begin
          check("pmem_rdata", pmem_rdata, exp_resp.pop_front());
        end
      end
    end
  end

  // Entered and left just after a rising edge; the entry cycle is cycle 0.
  task automatic run_txn(input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [31:0] ex_addr, input logic [255:0] line,
                         input int gap_after, input int gap_len,
                         input bit hold, input bit spur_done);
    pmem_write   = wr;
    pmem_read    = rd;
    pmem_address = addr;
    if (wr) pmem_wdata = line;
    exp_addr = ex_addr;
    exp_kind = wr ? 2 : 1;
    if (wr) begin
      for (int b = 0; b < 4; b++) exp_wbeat.push_back(line[b*64 +: 64]);
      exp_resp.push_back(model_rbuf);
    end else begin
      model_rbuf = line;
      exp_resp.push_back(line);
    end
    @(posedge clk); #1;
    check("bus_req_cycle1", {254'd0, read_o, write_o}, wr ? 256'd1 : 256'd2);
    if (wr) pmem_wdata = ~line;
    pmem_address = ~addr;
    for (int b = 0; b < 4; b++) begin
      resp_i  = 1'b1;
      burst_i = wr ? 64'hBAD0_BAD0_BAD0_BAD0 : line[b*64 +: 64];
      @(posedge clk); #1;
      resp_i  = 1'b0;
      burst_i = '0;
      if (b == gap_after) repeat (gap_len) begin @(posedge clk); #1; end
    end
    check("resp_at_latency", {255'd0, pmem_resp}, 256'd1);
    if (!hold) begin
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
    end
    if (spur_done) begin
      resp_i  = 1'b1;
      burst_i = 64'hFFFF_0000_FFFF_0000;
    end
    @(posedge clk); #1;
    resp_i  = 1'b0;
    burst_i = '0;
    check("idle_after_done", {253'd0, pmem_resp, read_o, write_o}, 256'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = '0; pmem_wdata = '0;
    burst_i = '0; resp_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", {219'd0, pmem_resp, read_o, write_o, address_o, burst_o == 64'd0},
          256'd1);
    check("rst_rdata", pmem_rdata, 256'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain read, no gaps: pmem_resp in cycle 5, address aligned.
    run_txn(1'b0, 1'b1, 32'h1234_5677, 32'h1234_5660, R1, -1, 0, 1'b0, 1'b0);

    // Write with a 2-cycle gap after beat 1.
    run_txn(1'b1, 1'b0, 32'h8000_003F, 32'h8000_0020, W1, 1, 2, 1'b0, 1'b0);

    // Spurious resp_i while idle must not disturb rbuf or counter.
    resp_i = 1'b1; burst_i = 64'hDEAD_DEAD_DEAD_DEAD;
    repeat (3) begin @(posedge clk); #1; end
    resp_i = 1'b0; burst_i = '0;
    check("idle_spur_rdata", pmem_rdata, R1);
    check("idle_spur_bus", {254'd0, read_o, write_o}, 256'd0);

    // Read and write together: write wins; spurious resp_i in DONE.
    run_txn(1'b1, 1'b1, 32'h0000_1001, 32'h0000_1000, W2, -1, 0, 1'b0, 1'b1);
    check("after_both_rdata", pmem_rdata, R1);

    // Read after spurious strobes: beats must land from beat 0 again.
    run_txn(1'b0, 1'b1, 32'h4000_0010, 32'h4000_0000, R2, 2, 1, 1'b0, 1'b0);

    // Reset asserted mid-read after beat index 2.
    pmem_read = 1'b1; pmem_address = 32'hCAFE_0044;
    exp_addr = 32'hCAFE_0040; exp_kind = 1;
    @(posedge clk); #1;
    for (int b = 0; b < 3; b++) begin
      resp_i = 1'b1; burst_i = R3[b*64 +: 64];
      @(posedge clk); #1;
    end
    resp_i = 1'b0; burst_i = '0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_bus", {221'd0, pmem_resp, read_o, write_o, address_o}, 256'd0);
    check("async_rst_rdata", pmem_rdata, 256'd0);
    model_rbuf = '0;
    pmem_read  = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(1'b0, 1'b1, 32'hCAFE_0044, 32'hCAFE_0040, R3, -1, 0, 1'b0, 1'b0);

    // Back-to-back: request held through DONE and the following IDLE cycle.
    run_txn(1'b0, 1'b1, 32'h0000_00E0, 32'h0000_00E0, R2, -1, 0, 1'b1, 1'b0);
    run_txn(1'b0, 1'b1, 32'h0000_0100, 32'h0000_0100, R1, 0, 1, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("resp_queue_drained", 256'(exp_resp.size()), 256'd0);
    check("wbeat_queue_drained", 256'(exp_wbeat.size()), 256'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
